cache_request_queue: RTL and testbench

- Request buffer upstream of the data/instruction cache.
- Accepts read and write requests from the pipeline memory stage into a FIFO and issues them one at a time to the cache using its read/write/ready/valid interface.
- Waits for read data, retries reads that time out, and returns read responses to the pipeline.
- Decouples pipeline issue from cache stall periods (ready low).

---
 rtl/cache_request_queue.sv | 160 ++++++++++++++++
 tb/tb_cache_request_queue.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_request_queue.sv
// Request FIFO between the pipeline memory stage and the cache: issues entries in order,
// one at a time, waits for read data, reissues reads that time out and returns read responses.
module cache_request_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12,
    parameter int QUEUE_DEPTH  = 4,
    parameter int READ_TIMEOUT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_read,
    input  logic                    req_write,
    input  logic [ADDRESS_BITS-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    req_stall,
    output logic                    resp_valid,
    output logic [ADDRESS_BITS-1:0] resp_address,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    cache_read,
    output logic                    cache_write,
    output logic [ADDRESS_BITS-1:0] cache_address,
    output logic [DATA_WIDTH-1:0]   cache_in_data,
    input  logic                    cache_ready,
    input  logic                    cache_valid,
    input  logic [ADDRESS_BITS-1:0] cache_out_addr,
    input  logic [DATA_WIDTH-1:0]   cache_out_data,
    output logic                    busy
);

    localparam int PTR_BITS   = $clog2(QUEUE_DEPTH);
    localparam int COUNT_BITS = PTR_BITS + 1;
    localparam int TIMER_BITS = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;

    localparam logic [COUNT_BITS-1:0] FULL_COUNT = COUNT_BITS'(QUEUE_DEPTH);
    localparam logic [COUNT_BITS-1:0] ONE_COUNT  = COUNT_BITS'(1);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(READ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    logic                    entry_write   [QUEUE_DEPTH];
    logic [ADDRESS_BITS-1:0] entry_address [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]   entry_data    [QUEUE_DEPTH];

    logic [PTR_BITS-1:0]     write_ptr;
    logic [PTR_BITS-1:0]     read_ptr;
    logic [COUNT_BITS-1:0]   count;
    state_t                  state;
    logic [TIMER_BITS-1:0]   wait_count;

    logic                    push;
    logic                    pop;
    logic                    head_write;
    logic [ADDRESS_BITS-1:0] head_address;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    read_match;
    logic                    more_entries;

    // Full is decoded from the registered count, so a same-cycle pop never frees a slot early.
    assign req_stall    = (count == FULL_COUNT);
    assign push         = (req_read | req_write) & ~req_stall;

    assign head_write   = entry_write[read_ptr];
    assign head_address = entry_address[read_ptr];
    assign head_data    = entry_data[read_ptr];

    assign read_match   = cache_valid & (cache_out_addr == head_address);
    assign more_entries = (count > ONE_COUNT);

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_ISSUE: pop = cache_ready & head_write;
            ST_WAIT:  pop = read_match;
            default:  pop = 1'b0;
        endcase
    end

    // NOTE: the entry storage has no reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_write[write_ptr]   <= req_write;
            entry_address[write_ptr] <= req_address;
            entry_data[write_ptr]    <= req_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                write_ptr <= write_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                read_ptr <= read_ptr + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_count   <= '0;
            resp_valid   <= 1'b0;
            resp_address <= '0;
            resp_data    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cache_ready) begin
                        if (head_write) begin
                            state <= more_entries ? ST_ISSUE : ST_IDLE;
                        end else begin
                            state      <= ST_WAIT;
                            wait_count <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_count <= wait_count + TIMER_BITS'(1);
                    if (read_match) begin
                        resp_valid   <= 1'b1;
                        resp_address <= head_address;
                        resp_data    <= cache_out_data;
                        state        <= more_entries ? ST_ISSUE : ST_IDLE;
                    end else if (wait_count == TIMER_LAST) begin
                        // Timed out: the head read stays queued and is issued again.
                        state <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The cache request is driven straight from the head entry so it appears the cycle ISSUE is entered.
    assign cache_read    = (state == ST_ISSUE) & ~head_write;
    assign cache_write   = (state == ST_ISSUE) & head_write;
    assign cache_address = (state == ST_IDLE) ? '0 : head_address;
    assign cache_in_data = (state == ST_ISSUE) ? head_data : '0;
    assign busy          = (state != ST_IDLE) | (count != '0);

endmodule

// File: tb/tb_cache_request_queue.sv
// Bench for cache_request_queue: directed cycle checks plus a randomized run scored against
// a transaction-level model (request queue, memory image, outstanding-read window).
module tb_cache_request_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clock;
    logic        reset;
    logic        req_read;
    logic        req_write;
    logic [11:0] req_address;
    logic [31:0] req_data;
    logic        req_stall;
    logic        resp_valid;
    logic [11:0] resp_address;
    logic [31:0] resp_data;
    logic        cache_read;
    logic        cache_write;
    logic [11:0] cache_address;
    logic [31:0] cache_in_data;
    logic        cache_ready;
    logic        cache_valid;
    logic [11:0] cache_out_addr;
    logic [31:0] cache_out_data;
    logic        busy;

    cache_request_queue #(
        .DATA_WIDTH  (32),
        .ADDRESS_BITS(12),
        .QUEUE_DEPTH (DEPTH),
        .READ_TIMEOUT(TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_data      (req_data),
        .req_stall     (req_stall),
        .resp_valid    (resp_valid),
        .resp_address  (resp_address),
        .resp_data     (resp_data),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_address (cache_address),
        .cache_in_data (cache_in_data),
        .cache_ready   (cache_ready),
        .cache_valid   (cache_valid),
        .cache_out_addr(cache_out_addr),
        .cache_out_data(cache_out_data),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_write;
        logic [11:0] addr;
        logic [31:0] data;
    } entry_t;

    int          n_tests = 0;
    int          n_fail  = 0;

    entry_t      model_q[$];
    logic [31:0] mem [logic [11:0]];
    bit          out_active;
    int          out_age;
    int          out_delay;
    logic [11:0] out_addr;
    bit          exp_resp;
    logic [11:0] exp_addr;
    logic [31:0] exp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_read       = 1'b0;
        req_write      = 1'b0;
        req_address    = '0;
        req_data       = '0;
        cache_ready    = 1'b0;
        cache_valid    = 1'b0;
        cache_out_addr = '0;
        cache_out_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, req_stall, 1'b0);
        check({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_resp_addr"}, resp_address, 12'h0);
        check({tag, "_resp_data"}, resp_data, 32'h0);
        check({tag, "_cache_rd"}, cache_read, 1'b0);
        check({tag, "_cache_wr"}, cache_write, 1'b0);
        check({tag, "_cache_addr"}, cache_address, 12'h0);
        check({tag, "_cache_data"}, cache_in_data, 32'h0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // Accepts the next read issued to the cache and answers it one cycle after the handshake.
    task automatic serve_read(input string tag, input logic [11:0] addr, input logic [31:0] data);
        int guard = 0;
        cache_ready = 1'b1;
        while (!cache_read && guard < 20) begin
            step();
            guard++;
        end
        check({tag, "_issued"}, cache_read, 1'b1);
        check({tag, "_addr"}, cache_address, addr);
        step();
        cache_valid    = 1'b1;
        cache_out_addr = addr;
        cache_out_data = data;
        step();
        cache_valid = 1'b0;
        check({tag, "_resp_valid"}, resp_valid, 1'b1);
        check({tag, "_resp_addr"}, resp_address, addr);
        check({tag, "_resp_data"}, resp_data, data);
    endtask

    function automatic logic [31:0] mem_read(input logic [11:0] a);
        if (mem.exists(a)) return mem[a];
        return {20'hC0DE0, a};
    endfunction

    // One randomized cycle: score the DUT outputs, drive new inputs, advance the model.
    task automatic rand_cycle(input bit allow_push);
        bit     issuing;
        bit     stall_now;
        bit     send_match;
        int     kind;
        entry_t e;

        step();
        if (out_active) begin
            out_age++;
            if (out_age > TIMEOUT) begin
                out_active = 1'b0;
                check("rnd_retry_read", cache_read, 1'b1);
                check("rnd_retry_addr", cache_address, out_addr);
            end
        end

        stall_now = (model_q.size() == DEPTH);
        check("rnd_stall", req_stall, stall_now);
        check("rnd_busy", busy, model_q.size() != 0);
        check("rnd_resp_valid", resp_valid, exp_resp);
        if (exp_resp) begin
            check("rnd_resp_addr", resp_address, exp_addr);
            check("rnd_resp_data", resp_data, exp_data);
        end

        issuing = 1'b0;
        if (out_active) begin
            check("rnd_wait_quiet", {cache_read, cache_write}, 2'b00);
            check("rnd_wait_addr", cache_address, out_addr);
        end else if (cache_read || cache_write) begin
            check("rnd_issue_nonempty", model_q.size() != 0, 1'b1);
            if (model_q.size() != 0) begin
                issuing = 1'b1;
                check("rnd_issue_kind", {cache_write, cache_read}, {model_q[0].is_write, !model_q[0].is_write});
                check("rnd_issue_addr", cache_address, model_q[0].addr);
                if (model_q[0].is_write) check("rnd_issue_data", cache_in_data, model_q[0].data);
            end
        end

        kind           = allow_push ? $urandom_range(0, 3) : 0;
        req_read       = (kind == 1) || (kind == 3);
        req_write      = (kind >= 2);
        req_address    = 12'($urandom_range(0, 15));
        req_data       = $urandom;
        cache_ready    = ($urandom_range(0, 3) != 0);
        cache_valid    = 1'b0;
        cache_out_addr = 12'($urandom);
        cache_out_data = $urandom;
        send_match     = 1'b0;
        if (out_active) begin
            if (out_delay != 0 && out_age == out_delay) begin
                send_match     = 1'b1;
                cache_valid    = 1'b1;
                cache_out_addr = out_addr;
                cache_out_data = mem_read(out_addr);
            end else if ($urandom_range(0, 4) == 0) begin
                cache_valid    = 1'b1;
                cache_out_addr = out_addr ^ 12'h800;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            cache_valid = 1'b1;
        end

        exp_resp = 1'b0;
        if (send_match) begin
            exp_resp   = 1'b1;
            exp_addr   = out_addr;
            exp_data   = cache_out_data;
            out_active = 1'b0;
            model_q.delete(0);
        end else if (issuing && cache_ready) begin
            if (model_q[0].is_write) begin
                mem[model_q[0].addr] = model_q[0].data;
                model_q.delete(0);
            end else begin
                out_active = 1'b1;
                out_age    = 0;
                out_addr   = model_q[0].addr;
                out_delay  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
            end
        end
        if ((req_read || req_write) && !stall_now) begin
            e.is_write = req_write;
            e.addr     = req_address;
            e.data     = req_data;
            model_q.push_back(e);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        do_reset();
        check_all_zero("reset");

        // Write then read of the same address.
        req_write   = 1'b1;
        req_address = 12'h0A5;
        req_data    = 32'hDEADBEEF;
        cache_ready = 1'b1;
        step();
        check("t1_c1_quiet", {cache_read, cache_write}, 2'b00);
        check("t1_c1_busy", busy, 1'b1);
        req_write   = 1'b0;
        req_read    = 1'b1;
        req_data    = '0;
        step();
        req_read = 1'b0;
        check("t1_wr", {cache_write, cache_read}, 2'b10);
        check("t1_wr_addr", cache_address, 12'h0A5);
        check("t1_wr_data", cache_in_data, 32'hDEADBEEF);
        step();
        check("t1_rd", {cache_write, cache_read}, 2'b01);
        check("t1_rd_addr", cache_address, 12'h0A5);
        step();
        check("t1_wait_quiet", cache_read, 1'b0);
        step();
        cache_valid    = 1'b1;
        cache_out_addr = 12'h0A5;
        cache_out_data = 32'hDEADBEEF;
        step();
        cache_valid = 1'b0;
        check("t1_resp_valid", resp_valid, 1'b1);
        check("t1_resp_addr", resp_address, 12'h0A5);
        check("t1_resp_data", resp_data, 32'hDEADBEEF);
        check("t1_idle_busy", busy, 1'b0);
        step();
        check("t1_resp_pulse", resp_valid, 1'b0);
        check("t1_resp_hold", resp_data, 32'hDEADBEEF);

        // Fill the queue while the cache is stalled, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_stall_%0d", i), req_stall, i == 4);
            req_read    = 1'b1;
            req_address = 12'h100 + 12'(i);
            step();
        end
        req_read = 1'b0;
        check("t2_still_full", req_stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            serve_read($sformatf("t2_drain_%0d", i), 12'h100 + 12'(i), 32'hA000_0000 + 32'(i));
        end
        check("t2_drained_busy", busy, 1'b0);
        step();
        check("t2_no_fifth", cache_read, 1'b0);
        check("t2_no_fifth_busy", busy, 1'b0);

        // Cache stalls for three cycles while a read sits in ISSUE.
        do_reset();
        req_read    = 1'b1;
        req_address = 12'h2C3;
        step();
        req_read = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_hold_rd_%0d", k), cache_read, 1'b1);
            check($sformatf("t3_hold_addr_%0d", k), cache_address, 12'h2C3);
            step();
        end
        cache_ready = 1'b1;
        check("t3_issue_rd", cache_read, 1'b1);
        check("t3_issue_addr", cache_address, 12'h2C3);
        step();
        check("t3_accepted", cache_read, 1'b0);
        cache_valid    = 1'b1;
        cache_out_addr = 12'h2C3;
        cache_out_data = 32'h0BAD_F00D;
        step();
        cache_valid = 1'b0;
        check("t3_resp_valid", resp_valid, 1'b1);
        check("t3_resp_data", resp_data, 32'h0BAD_F00D);

        // Read timeout and retry, then an address mismatch before completion.
        do_reset();
        cache_ready = 1'b1;
        req_read    = 1'b1;
        req_address = 12'h010;
        step();
        req_read = 1'b0;
        step();
        check("t4_first_issue", cache_read, 1'b1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            check($sformatf("t4_wait_rd_%0d", k), cache_read, 1'b0);
            check($sformatf("t4_wait_resp_%0d", k), resp_valid, 1'b0);
        end
        step();
        check("t4_retry_rd", cache_read, 1'b1);
        check("t4_retry_addr", cache_address, 12'h010);
        step();
        check("t4_retry_wait", cache_read, 1'b0);
        step();
        cache_valid    = 1'b1;
        cache_out_addr = 12'h011;
        cache_out_data = 32'hAAAA5555;
        step();
        check("t5_mismatch_resp", resp_valid, 1'b0);
        cache_out_addr = 12'h010;
        cache_out_data = 32'h12345678;
        step();
        cache_valid = 1'b0;
        check("t5_resp_valid", resp_valid, 1'b1);
        check("t5_resp_addr", resp_address, 12'h010);
        check("t5_resp_data", resp_data, 32'h12345678);
        step();
        check("t5_single_resp", resp_valid, 1'b0);
        check("t5_idle_busy", busy, 1'b0);

        // Reset while a read is outstanding and the queue is full.
        do_reset();
        cache_ready = 1'b1;
        req_read    = 1'b1;
        req_address = 12'h3F0;
        step();
        req_read  = 1'b0;
        req_write = 1'b1;
        req_data  = 32'h55;
        for (int k = 1; k <= 3; k++) begin
            req_address = 12'h3F0 + 12'(k);
            step();
        end
        req_write = 1'b0;
        check("t6_full", req_stall, 1'b1);
        check("t6_in_wait", cache_read, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("t6_after_reset");
        cache_valid    = 1'b1;
        cache_out_addr = 12'h3F0;
        cache_out_data = 32'h0000_0BAD;
        step();
        cache_valid = 1'b0;
        check("t6_stale_resp", resp_valid, 1'b0);
        check("t6_stale_busy", busy, 1'b0);
        step();
        check("t6_no_issue", {cache_read, cache_write}, 2'b00);
        check("t6_no_resp", resp_valid, 1'b0);

        // Randomized traffic scored against the transaction model.
        do_reset();
        model_q.delete();
        mem.delete();
        out_active = 1'b0;
        exp_resp   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_cycle(1'b1);
        end
        begin
            int guard = 0;
            while ((model_q.size() != 0 || out_active) && guard < 2000) begin
                rand_cycle(1'b0);
                guard++;
            end
            check("rnd_drain_done", model_q.size(), 0);
            rand_cycle(1'b0);
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
